// File: rtl/rom_arb_pkg.sv
// Shared types for the two-port ROM arbiter: port indices, port count,
// and the registered response tag.
package rom_arb_pkg;

   localparam int NUM_PORTS = 2;

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   // Owner of the read whose data arrives next cycle
   typedef struct packed {
      logic  vld;
      port_e owner;
   } rsp_t;

   function automatic logic [NUM_PORTS-1:0] port_onehot(input port_e p);
      return NUM_PORTS'(1) << p;
   endfunction

endpackage

// File: rtl/rom_arb_picker.sv
// Tie-break for the ROM arbiter: one-hot grant from the request vector.
// ROM_ARB_RR_EN selects round-robin (with a last_winner register);
// without it port 1 (data) always wins a tie.
module rom_arb_picker
   import rom_arb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req,
   output logic [NUM_PORTS-1:0] gnt
);

   port_e win;

`ifdef ROM_ARB_RR_EN
   port_e last_winner;

   // Lone request wins outright; a tie goes to the port that did not win last
   always_comb begin
      win = PORT_INSTR;
      if (req[PORT_DATA] && !req[PORT_INSTR])
         win = PORT_DATA;
      else if (req[PORT_DATA] && req[PORT_INSTR])
         win = (last_winner == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
   end

   // Track the winner of every grant; reset value makes the first tie go to port 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_winner <= PORT_DATA;
      else if (|req)
         last_winner <= win;
   end
`else
   logic unused_clk;
   assign unused_clk = clk;

   // Fixed priority: data port wins whenever it asks
   always_comb begin
      win = PORT_INSTR;
      if (req[PORT_DATA])
         win = PORT_DATA;
   end
`endif

   // No grant while in reset or with nothing requested
   always_comb begin
      gnt = '0;
      if (!rst && |req)
         gnt = port_onehot(win);
   end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single-port ROM with 1-cycle read latency.
// Port 0 = instruction fetch, port 1 = data load. Grants are combinational,
// responses come back exactly one cycle later on the granted port.
// Optional macro: ROM_ARB_RR_EN (round-robin tie-break instead of fixed priority).
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   logic [NUM_PORTS-1:0]                 req;
   logic [NUM_PORTS-1:0]                 gnt;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr;
   rsp_t                                 rsp;

   assign req  = {req1, req0};
   assign addr = {addr1, addr0};

   rom_arb_picker u_picker (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   assign gnt0 = gnt[PORT_INSTR];
   assign gnt1 = gnt[PORT_DATA];

   // Winner's address goes to the ROM; idle cycles park the address at 0
   always_comb begin
      ram_addr = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         if (gnt[p])
            ram_addr = addr[p];
   end

   // Tag the read in flight so its data returns on the right port next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp.vld   <= 1'b0;
         rsp.owner <= PORT_INSTR;
      end else begin
         rsp.vld   <= |gnt;
         rsp.owner <= gnt[PORT_DATA] ? PORT_DATA : PORT_INSTR;
      end
   end

   assign rvalid0 = rsp.vld && (rsp.owner == PORT_INSTR);
   assign rvalid1 = rsp.vld && (rsp.owner == PORT_DATA);

   // ROM data is broadcast; rvalid alone says whose it is
   assign rdata0 = ram_rdata;
   assign rdata1 = ram_rdata;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter. Inputs change just after the falling edge,
// grants are sampled 1ns later, registered outputs are sampled at the next
// falling edge. Expectations follow ROM_ARB_RR_EN when it is defined.
module tb_rom_arbiter;

`ifdef ROM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk, rst;
   logic        req0, req1;
   logic [7:0]  addr0, addr1, ram_addr;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata0, rdata1, ram_rdata;
   logic        pg0, pg1;
   int          nasrt, nfail;

   rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .addr0     (addr0),
      .gnt0      (gnt0),
      .rvalid0   (rvalid0),
      .rdata0    (rdata0),
      .req1      (req1),
      .addr1     (addr1),
      .gnt1      (gnt1),
      .rvalid1   (rvalid1),
      .rdata1    (rdata1),
      .ram_addr  (ram_addr),
      .ram_rdata (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: 1-cycle synchronous read
   always @(posedge clk)
      ram_rdata <= {24'h0, ram_addr} ^ 32'hA5A5_0000;

   function automatic logic [31:0] rom(input logic [7:0] a);
      return {24'h0, a} ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nasrt++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: protocol checks on registered outputs, then drive and settle
   task automatic cyc(input logic r, input logic r0, input logic [7:0] a0,
                      input logic r1, input logic [7:0] a1);
      @(negedge clk);
      chk("rvalid_onehot", 32'($onehot0({rvalid0, rvalid1})), 32'd1);
      chk("rvalid0_follows_gnt0", 32'(rvalid0), 32'(pg0));
      chk("rvalid1_follows_gnt1", 32'(rvalid1), 32'(pg1));
      rst = r; req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
      #1;
      chk("gnt_onehot", 32'($onehot0({gnt0, gnt1})), 32'd1);
      pg0 = gnt0;
      pg1 = gnt1;
   endtask

   initial begin
      logic [31:0] exp_prev;
      logic        exp_g1;
      nasrt = 0; nfail = 0;
      pg0 = 1'b0; pg1 = 1'b0;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

      // Reset state, even with both ports requesting
      cyc(1'b1, 1'b1, 8'h10, 1'b1, 8'h20);
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      cyc(1'b1, 1'b1, 8'h10, 1'b1, 8'h20);
      chk("rst_rvalid0", 32'(rvalid0), 32'd0);
      chk("rst_rvalid1", 32'(rvalid1), 32'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("idle_ram_addr", 32'(ram_addr), 32'd0);

      // Tie from reset: RR -> port 0 first, fixed -> port 1 first
      cyc(1'b0, 1'b1, 8'h01, 1'b1, 8'h02);
      chk("tie_gnt0", 32'(gnt0), 32'(RR));
      chk("tie_gnt1", 32'(gnt1), 32'(!RR));
      chk("tie_ram_addr", 32'(ram_addr), RR ? 32'h01 : 32'h02);
      if (RR) cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h02);
      else    cyc(1'b0, 1'b1, 8'h01, 1'b0, 8'h00);
      chk("tie_loser_gnt0", 32'(gnt0), 32'(!RR));
      chk("tie_loser_gnt1", 32'(gnt1), 32'(RR));
      chk("tie_rsp1_rvalid0", 32'(rvalid0), 32'(RR));
      chk("tie_rsp1_rdata", RR ? rdata0 : rdata1, RR ? 32'hA5A5_0001 : 32'hA5A5_0002);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("tie_rsp2_rvalid1", 32'(rvalid1), 32'(RR));
      chk("tie_rsp2_rdata", RR ? rdata1 : rdata0, RR ? 32'hA5A5_0002 : 32'hA5A5_0001);
      chk("idle_gnt", 32'({gnt0, gnt1}), 32'd0);

      // Lone request on port 0
      cyc(1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
      chk("lone_gnt0", 32'(gnt0), 32'd1);
      chk("lone_ram_addr", 32'(ram_addr), 32'h10);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("lone_rvalid0", 32'(rvalid0), 32'd1);
      chk("lone_rdata0", rdata0, 32'hA5A5_0010);
      chk("lone_rvalid1", 32'(rvalid1), 32'd0);

      // Both held for 4 cycles: fixed priority starves port 0, RR alternates
      // (last winner was port 0, so RR starts with port 1)
      exp_prev = '0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 8'h40, 1'b1, 8'(8'h30 + i));
         exp_g1 = RR ? (i % 2 == 0) : 1'b1;
         chk("hold_gnt1", 32'(gnt1), 32'(exp_g1));
         chk("hold_gnt0", 32'(gnt0), 32'(!exp_g1));
         if (i > 0) chk("hold_rdata", rvalid1 ? rdata1 : rdata0, exp_prev);
         exp_prev = exp_g1 ? rom(8'(8'h30 + i)) : rom(8'h40);
      end

      // Streaming on port 0, no bubbles
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
         chk("stream_gnt0", 32'(gnt0), 32'd1);
         chk("stream_ram_addr", 32'(ram_addr), 32'(i));
         if (i > 0) begin
            chk("stream_rvalid0", 32'(rvalid0), 32'd1);
            chk("stream_rdata0", rdata0, rom(8'(i - 1)));
         end
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("stream_last_rvalid0", 32'(rvalid0), 32'd1);
      chk("stream_last_rdata0", rdata0, 32'hA5A5_0007);

      // Reset pulsed right after a port 1 grant: its response is dropped
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h55);
      chk("midrst_gnt1", 32'(gnt1), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      pg0 = 1'b0;
      pg1 = 1'b0;
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("midrst_rvalid1_a", 32'(rvalid1), 32'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("midrst_rvalid1_b", 32'(rvalid1), 32'd0);
      cyc(1'b0, 1'b1, 8'h03, 1'b1, 8'h04);
      chk("midrst_rvalid1_c", 32'(rvalid1), 32'd0);
      chk("post_rst_tie_gnt0", 32'(gnt0), 32'(RR));
      chk("post_rst_tie_gnt1", 32'(gnt1), 32'(!RR));
      if (RR) cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h04);
      else    cyc(1'b0, 1'b1, 8'h03, 1'b0, 8'h00);
      chk("post_rst_rdata", RR ? rdata0 : rdata1, RR ? 32'hA5A5_0003 : 32'hA5A5_0004);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("post_rst_rdata2", RR ? rdata1 : rdata0, RR ? 32'hA5A5_0004 : 32'hA5A5_0003);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end

endmodule
